// File: rtl/or_evt_pkg.sv
// Shared constants for the OR-vector event collector.
// Default widths match the 3-bit orgate_3bit result it monitors.
package or_evt_pkg;

    localparam int OR_EVT_WIDTH = 3;
    localparam int OR_EVT_CNT_W = 8;
    localparam int OR_EVT_DEPTH = 4;
    localparam int OR_EVT_TS_W  = 16;

endpackage

// File: rtl/or_event_collector_if.sv
// Event record stream: valid/ready handshake carrying a rising-edge
// mask and timestamp. master = collector, slave = consumer.
interface or_event_collector_if
    import or_evt_pkg::*;
#(
    parameter int WIDTH = OR_EVT_WIDTH,
    parameter int TS_W  = OR_EVT_TS_W
) ();

    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_mask;
    logic [TS_W-1:0]  evt_time;

    modport master (
        output evt_valid,
        output evt_mask,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_mask,
        input  evt_time,
        output evt_ready
    );

endinterface

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO; head is on data_out whenever !empty.
// Ports: push/data_in write, pop read, empty/full/level status.
module evt_fifo
    import or_evt_pkg::*;
#(
    parameter int DATA_W = OR_EVT_WIDTH + OR_EVT_TS_W,
    parameter int DEPTH  = OR_EVT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;

    // A pop frees a slot, so a push into a full FIFO may proceed with it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign data_out = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/or_event_collector.sv
// Watches the OR vector for rising edges: saturating per-bit counters,
// sticky flags, and a FIFO of {mask, timestamp} records on evt.
// Ports: clk, rst (sync, active-high), in_vec, clr, evt (master),
// cnt_flat, sticky, overflow, fifo_level.
module or_event_collector
    import or_evt_pkg::*;
#(
    parameter int WIDTH = OR_EVT_WIDTH,
    parameter int CNT_W = OR_EVT_CNT_W,
    parameter int DEPTH = OR_EVT_DEPTH,
    parameter int TS_W  = OR_EVT_TS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_vec,
    input  logic                     clr,
    or_event_collector_if.master     evt,
    output logic [WIDTH*CNT_W-1:0]   cnt_flat,
    output logic [WIDTH-1:0]         sticky,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int DW = WIDTH + TS_W;

    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] rise;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic             ovf_q, ovf_d;

    logic             push;
    logic             drop;
    logic             f_empty;
    logic             f_full;
    logic [DW-1:0]    f_dout;

    // in_q is zero after reset, so a bit already high counts as a rise.
    assign rise = in_vec & ~in_q;
    assign push = |rise;

    // Drop only when full and the consumer is not freeing a slot.
    assign drop = push && f_full && !evt.evt_ready;

    evt_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  ({rise, ts_q}),
        .pop      (evt.evt_ready),
        .data_out (f_dout),
        .empty    (f_empty),
        .full     (f_full),
        .level    (fifo_level)
    );

    assign evt.evt_valid = !f_empty;
    assign evt.evt_mask  = f_dout[DW-1:TS_W];
    assign evt.evt_time  = f_dout[TS_W-1:0];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = CNT_W'(rise[i]);
            end else if (rise[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        sticky_d = clr ? rise : (sticky_q | rise);
        ovf_d    = clr ? drop : (ovf_q | drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q     <= '0;
            ts_q     <= '0;
            sticky_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            in_q     <= in_vec;
            ts_q     <= ts_q + 1'b1;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
        assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign sticky   = sticky_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_or_event_collector.sv
// Self-checking bench for or_event_collector: fixed vector table,
// directed corner sequences and randomized traffic vs a queue model.
module tb_or_event_collector;
    import or_evt_pkg::*;

    localparam int W  = 3;
    localparam int CW = 8;
    localparam int D  = 4;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [W-1:0]    in_vec;
    logic [W*CW-1:0] cnt_flat;
    logic [W-1:0]    sticky;
    logic            overflow;
    logic [2:0]      fifo_level;

    always #5 clk = ~clk;

    or_event_collector_if evt ();

    or_event_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_vec),
        .clr        (clr),
        .evt        (evt),
        .cnt_flat   (cnt_flat),
        .sticky     (sticky),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    typedef struct packed {
        logic [W-1:0]  m;
        logic [TW-1:0] t;
    } rec_t;

    typedef struct {
        logic [W-1:0]  v;
        logic          rdy;
        logic          ev;
        logic [W-1:0]  em;
        logic [TW-1:0] et;
        int            el;
    } vec_t;

    rec_t         q[$];
    int           mcnt[W];
    logic [W-1:0] mprev;
    logic [W-1:0] msticky;
    logic         movf;
    int           mts;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic model_step(input logic r, input logic c,
                              input logic [W-1:0] v, input logic rdy);
        logic [W-1:0] rise;
        logic         drop;
        if (r) begin
            q.delete();
            foreach (mcnt[i]) mcnt[i] = 0;
            mprev   = '0;
            msticky = '0;
            movf    = 1'b0;
            mts     = 0;
        end else begin
            rise  = v & ~mprev;
            mprev = v;
            drop  = 1'b0;
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (rise != 0) begin
                if (q.size() < D) q.push_back({rise, 16'(mts)});
                else drop = 1'b1;
            end
            for (int i = 0; i < W; i++) begin
                if (c) mcnt[i] = int'(rise[i]);
                else if (mcnt[i] + int'(rise[i]) > 255) mcnt[i] = 255;
                else mcnt[i] = mcnt[i] + int'(rise[i]);
            end
            msticky = c ? rise : (msticky | rise);
            movf    = c ? drop : (movf | drop);
            mts     = (mts + 1) % 65536;
        end
    endtask

    task automatic cyc(input logic r, input logic c,
                       input logic [W-1:0] v, input logic rdy);
        logic [W*CW-1:0] ec;
        rst           = r;
        clr           = c;
        in_vec        = v;
        evt.evt_ready = rdy;
        @(posedge clk);
        #1;
        model_step(r, c, v, rdy);
        for (int i = 0; i < W; i++) ec[i*CW +: CW] = 8'(mcnt[i]);
        chk("valid", evt.evt_valid, q.size() > 0);
        chk("mask", evt.evt_mask, q.size() > 0 ? q[0].m : 0);
        chk("time", evt.evt_time, q.size() > 0 ? q[0].t : 0);
        chk("level", fifo_level, q.size());
        chk("cnt", cnt_flat, ec);
        chk("sticky", sticky, msticky);
        chk("overflow", overflow, movf);
    endtask

    vec_t tbl[12];

    initial begin
        int thr;
        rst           = 1'b1;
        clr           = 1'b0;
        in_vec        = '0;
        evt.evt_ready = 1'b0;

        tbl[0]  = '{3'b000, 1'b0, 1'b0, 3'b000, 16'd0, 0};
        tbl[1]  = '{3'b000, 1'b0, 1'b0, 3'b000, 16'd0, 0};
        tbl[2]  = '{3'b000, 1'b0, 1'b0, 3'b000, 16'd0, 0};
        tbl[3]  = '{3'b000, 1'b0, 1'b0, 3'b000, 16'd0, 0};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 3'b000, 16'd0, 0};
        tbl[5]  = '{3'b100, 1'b0, 1'b1, 3'b100, 16'd5, 1};
        tbl[6]  = '{3'b100, 1'b0, 1'b1, 3'b100, 16'd5, 1};
        tbl[7]  = '{3'b100, 1'b0, 1'b1, 3'b100, 16'd5, 1};
        tbl[8]  = '{3'b000, 1'b0, 1'b1, 3'b100, 16'd5, 1};
        tbl[9]  = '{3'b011, 1'b0, 1'b1, 3'b100, 16'd5, 2};
        tbl[10] = '{3'b011, 1'b1, 1'b1, 3'b011, 16'd9, 1};
        tbl[11] = '{3'b011, 1'b1, 1'b0, 3'b000, 16'd0, 0};

        // Reset, idle, single and multi-bit rises, pops.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, tbl[i].v, tbl[i].rdy);
            chk("tbl_valid", evt.evt_valid, tbl[i].ev);
            chk("tbl_mask", evt.evt_mask, tbl[i].em);
            chk("tbl_time", evt.evt_time, tbl[i].et);
            chk("tbl_level", fifo_level, tbl[i].el);
            if (i == 4) chk("idle_cnt", cnt_flat, 0);
        end
        chk("tbl_cnt", cnt_flat, 24'h010101);
        chk("tbl_sticky", sticky, 3'b111);

        // Five rises with no consumer: fourth fills, fifth drops.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 3'b001, 0);
            cyc(0, 0, 3'b000, 0);
        end
        chk("full_level", fifo_level, 4);
        chk("full_ovf", overflow, 1);
        for (int j = 0; j < 4; j++) begin
            chk("drain_time", evt.evt_time, 2 * j);
            cyc(0, 0, 0, 1);
        end
        chk("drain_empty", evt.evt_valid, 0);

        // Full FIFO with simultaneous pop and push.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 3'b001, 0);
            cyc(0, 0, 3'b000, 0);
        end
        cyc(0, 0, 3'b001, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_level", fifo_level, 4);
        for (int j = 0; j < 4; j++) begin
            chk("pp_time", evt.evt_time, 2 * j + 2);
            cyc(0, 0, 0, 1);
        end

        // Saturation, clear, clear with rise, mid-queue reset.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 260; k++) begin
            cyc(0, 0, 3'b001, 1);
            cyc(0, 0, 3'b000, 1);
        end
        chk("sat_cnt0", cnt_flat[7:0], 255);
        cyc(0, 1, 3'b000, 1);
        chk("clr_cnt", cnt_flat, 0);
        chk("clr_sticky", sticky, 0);
        cyc(0, 1, 3'b010, 1);
        chk("clr_rise_cnt", cnt_flat, 24'h000100);
        chk("clr_rise_sticky", sticky, 3'b010);
        cyc(0, 0, 3'b000, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 3'b001, 0);
            cyc(0, 0, 3'b000, 0);
        end
        chk("mid_level", fifo_level, 3);
        cyc(1, 0, 3'b000, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", evt.evt_valid, 0);

        // Randomized traffic with alternating consumer pressure.
        for (int n = 0; n < 3000; n++) begin
            thr = ((n / 250) % 2) ? 85 : 15;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 59) == 0,
                W'($urandom),
                $urandom_range(0, 99) < thr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/or_event_collector.md
Name: or_event_collector

Overview:
Sequential stage directly downstream of orgate_3bit that consumes its 3-bit OR result y.
- Registers the vector and detects per-bit rising edges.
- Keeps per-bit saturating edge counters and sticky flags.
- Queues timestamped edge records in a small show-ahead FIFO, drained through a valid/ready interface.

Parameters:
WIDTH, 3, bits in monitored vector (matches orgate_3bit y)
CNT_W, 8, width of each per-bit saturating edge counter
DEPTH, 4, event FIFO entries; power of 2, >=2
TS_W, 16, timestamp width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; synchronous and active-high
in_vec  in  WIDTH  monitored vector (orgate_3bit y)
clr  in  1  sync clear of counters, sticky, overflow
evt_valid  out  1  FIFO head record available
evt_ready  in  1  consumer accepts head record
evt_mask  out  WIDTH  head record rising-edge mask
evt_time  out  TS_W  head record timestamp
cnt_flat  out  WIDTH*CNT_W  per-bit counters; bit i at [i*CNT_W +: CNT_W]
sticky  out  WIDTH  per-bit "edge seen since clear"
overflow  out  1  sticky: a record was dropped
fifo_level  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst=1 at an edge), with priority over all else:
  - in_q, ts, counters, sticky, overflow = 0.
  - FIFO empty; evt_valid = 0, evt_mask = 0, evt_time = 0, fifo_level = 0.
  - Mid-operation reset discards queued records.
- Edge detect: rise = in_vec & ~in_q, evaluated from the value sampled at edge k. in_q <= in_vec every cycle. A bit already high on the first cycle after reset counts as a rise.
- Timestamp: ts increments every cycle and wraps 2^TS_W-1 -> 0. A record pushed at edge k carries ts as it was before that edge's increment.
- Latency: all effects of rise at edge k (counters, sticky, push) are visible immediately after edge k.
- Counters: cnt[i] += rise[i] and saturate at 2^CNT_W-1; no wrap.
- Sticky: sticky |= rise.
- clr=1 at edge k:
  - cnt[i] <= rise[i]; sticky <= rise.
  - overflow <= 1 only if a drop occurs at edge k, else 0.
  - FIFO is untouched.
- Push: occurs when |rise. Record = {rise, ts}. Multiple bits rising in one cycle produce one record.
- Pop: occurs when evt_valid && evt_ready.
- Full FIFO:
  - Push with no pop: record dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle: both proceed, no drop, level unchanged.
- Empty FIFO: evt_valid = 0. evt_mask/evt_time = 0. evt_ready is ignored.
- Push to an empty FIFO: record visible at head the cycle after the push. No same-cycle bypass.
- Handshake: head is stable while evt_valid && !evt_ready. Records leave in push order.
- fifo_level = pushes - pops, range 0..DEPTH.

Decomposition:
- Package or_evt_pkg: default constants OR_EVT_WIDTH=3, OR_EVT_CNT_W=8, OR_EVT_DEPTH=4, OR_EVT_TS_W=16.
- Sub-module evt_fifo: synchronous show-ahead FIFO, parameterised DATA_W and DEPTH.
  - Ports: push/data_in, pop, data_out, empty, full, level.
  - Uses pointers with an extra wrap bit.
  - Top instantiates it with DATA_W = WIDTH+TS_W.

Test Plan:
1. rst high 2 cycles, then in_vec=000 for 5 cycles -> evt_valid=0, cnt_flat=0, sticky=000, overflow=0, fifo_level=0.
2. After reset, hold 000 until ts=5, then 100 for 3 cycles, evt_ready=0 -> one record {100, 5}; cnt[2]=1; sticky=100; fifo_level=1.
3. in_vec 000 -> 011 in one cycle at ts=T -> single record mask 011, time T; cnt[0]=cnt[1]=1; pulse evt_ready 1 cycle -> evt_valid=0, level 0.
4. evt_ready=0, five separate rising events on bit0 (toggle 0/1) -> level 4, overflow=1 after 5th, records drain as events 1-4 in order with correct ts.
5. FIFO full, evt_ready=1 and new rise in the same cycle -> overflow stays 0, level stays 4, new record is last out.
6. Toggle bit0 for 260 rises -> cnt[0]=255. clr alone -> cnt 0, sticky 000. clr with bit1 rising -> cnt[1]=1, sticky=010. Assert rst mid-queue with level 3 -> level 0, evt_valid 0 next cycle.
